ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//  Device-side keyboard peripheral answering the MMIO keyboard read path.
//  Deserialises PS/2 frames from the keyboard pins and buffers scan codes in a FIFO.
//  Presents the FIFO head on kb_rdata, with kb_ready meaning "not empty".
//  Pops one entry on each clock where the MMIO raises sig_rd_kb.
// PARAMETERS
//  KB_W       8     scan-code width; equals `KbWidth
//  DEPTH      8     FIFO entries; power of two, >=2
//  TIMEOUT    2000  clk cycles with no PS/2 falling edge mid-frame before abort
// PORTS
//  clk        in   1     system clock; all state on posedge
//  rst_n      in   1     asynchronous, active-low reset
//  ps2_clk    in   1     raw keyboard clock pin; asynchronous
//  ps2_data   in   1     raw keyboard data pin; asynchronous
//  sig_rd_kb  in   1     pop request from MMIO; valid only while kb_ready=1
//  kb_rdata   out  KB_W  FIFO head data; combinational from FIFO storage
//  kb_ready   out  1     FIFO non-empty
//  overflow   out  1     sticky: a completed frame was dropped because FIFO was full
//  frame_err  out  1     1-cycle pulse: bad start/stop bit, bad parity, or timeout
// BEHAVIOUR
//  Reset values: kb_ready=0, kb_rdata=0, overflow=0, frame_err=0; FIFO empty; FSM IDLE.
//  Synchroniser: ps2_clk and ps2_data pass through a 2-FF chain each.
//  Falling-edge detect: registered previous ps2_clk_sync; fall = prev & ~cur.
//  The FSM advances only on a fall cycle, sampling the synchronised ps2_data.
//  FSM states and transitions (on fall):
//   - IDLE: data=0 -> DATA, bitcnt=0; data=1 -> stay in IDLE.
//   - DATA: shift data into bit[bitcnt], LSB first; after the 8th bit -> PARITY.
//   - PARITY: latch parity bit -> STOP.
//   - STOP: data=1 and frame good -> push byte; otherwise pulse frame_err. Then -> IDLE.
//  Timeout: outside IDLE, a counter counts cycles since the last fall.
//   - At TIMEOUT it pulses frame_err, returns to IDLE, and discards the partial byte.
//  Push timing: a push occurs the cycle after the STOP fall is detected.
//   - kb_ready rises on the following cycle; latency is 1 clk from the STOP sample.
//  Pop: on posedge with sig_rd_kb=1 and non-empty, the read pointer advances.
//   - kb_rdata shows the next entry from that edge onward.
//   - A pop when empty is ignored; no pointer movement.
//   - One pop per asserted cycle; sig_rd_kb held for N cycles pops N entries.
//  Simultaneous push and pop:
//   - Both take effect and the count is unchanged.
//   - When full, the simultaneous pop frees the slot and the push is accepted.
//  Full and push with no pop: the new byte is dropped and overflow sets.
//   - Overflow clears only on reset.
//  Pointers: log2(DEPTH)+1 bits; wrap naturally.
//   - Empty when pointers are equal; full when MSBs differ and the rest are equal.
//  Reset mid-frame or with data buffered: everything returns to reset values immediately.
//  KB_W > 8: the byte is zero-extended into kb_rdata.
// CONFIGURATION
//  PS2_PARITY_CHK_EN defined:
//   - A frame is good only if the 8 data bits plus the parity bit contain an odd number of 1s.
//   - A frame failing this is dropped and frame_err pulses.
//  Not defined: the parity bit is sampled and ignored; only the stop bit qualifies a frame.
// STRUCTURE
//  `KbWidth and the PS/2 frame constants live in defines.v:
//   - START=0, STOP=1, DATA_BITS=8.
//  FSM state encodings are localparams in this file.
//  One sub-module: kbd_fifo, a synchronous FIFO.
//   - Parameters: WIDTH, DEPTH.
//   - Ports: push, pop, wdata, rdata, empty, full, count.
//  ps2_kbd_rx instantiates kbd_fifo and holds the synchroniser, FSM and timeout counter.
// TESTING
//  1. Send frame 0x1C, odd parity=0, stop=1.
//     -> kb_ready=1 and kb_rdata=0x1C 1 clk after stop; pulse sig_rd_kb -> kb_ready=0.
//  2. Send 0xF0, 0x1C, 0x5A back-to-back with no pops.
//     -> kb_ready stays 1; three pops read F0, 1C, 5A in order, then kb_ready=0.
//  3. Send DEPTH+1 frames with no pop.
//     -> first DEPTH entries kept; overflow=1; the extra byte is absent on readout.
//  4. Frame 0x1C with wrong parity=1, PS2_PARITY_CHK_EN on.
//     -> frame_err pulse, kb_ready stays 0. Same frame with the macro off -> 0x1C pushed.
//  5. Send 4 data bits, then stop toggling.
//     -> frame_err pulses after TIMEOUT clks; a following good 0x29 frame is received correctly.
//  6. With FIFO full, a pop lands in the same cycle as a push of 0x33.
//     -> count stays DEPTH, overflow=0, 0x33 is read last.
//     Also: assert rst_n=0 mid-frame -> all outputs return to 0.

Source files
------------

// File: rtl/ps2_kbd_rx_pkg.sv
// Shared PS/2 frame constants, keyboard scan-code width and receiver FSM state type.
// Compile this file first so that `KbWidth is visible to the other files.
`ifndef KbWidth
`define KbWidth 8
`endif

package ps2_kbd_rx_pkg;

  localparam int unsigned PS2_START     = 0;
  localparam int unsigned PS2_STOP      = 1;
  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W     = $clog2(PS2_DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push into a full FIFO is accepted only
// when a pop happens in the same cycle. The head reads as zero while the FIFO is empty.
module kbd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchroniser, frame FSM with timeout, and scan-code FIFO.
// Define PS2_PARITY_CHK_EN to reject frames whose data+parity bits are not odd.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int unsigned KB_W    = `KbWidth,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic            sig_rd_kb,
  output logic [KB_W-1:0] kb_rdata,
  output logic            kb_ready,
  output logic            overflow,
  output logic            frame_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);
`ifdef PS2_PARITY_CHK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic                     clk_s1, clk_s2, clk_prev;
  logic                     data_s1, data_s2;
  logic                     fall;
  ps2_state_e               state;
  logic [BIT_CNT_W-1:0]     bitcnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par;
  logic [TW-1:0]            tmo;
  logic                     push_req;
  logic                     frame_good;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [AW:0]              fifo_count;

  // Idle line level is high, so synchroniser resets to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall       = clk_prev && !clk_s2;
  assign frame_good = (data_s2 == 1'(PS2_STOP)) && (!PARITY_EN || (^{shreg, par}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tmo       <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        tmo <= '0;
        unique case (state)
          ST_IDLE: begin
            if (data_s2 == 1'(PS2_START)) begin
              state  <= ST_DATA;
              bitcnt <= '0;
              shreg  <= '0;
            end
          end
          ST_DATA: begin
            shreg[bitcnt] <= data_s2;
            if (bitcnt == BIT_CNT_W'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
            else bitcnt <= bitcnt + BIT_CNT_W'(1);
          end
          ST_PARITY: begin
            par   <= data_s2;
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (frame_good) push_req <= 1'b1;
            else            frame_err <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // Stalled mid-frame: abandon the partial byte.
        if (tmo == TW'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
          tmo       <= '0;
        end else begin
          tmo <= tmo + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (push_req && fifo_full && !sig_rd_kb) overflow <= 1'b1;
  end

  kbd_fifo #(
    .WIDTH (KB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (sig_rd_kb && !fifo_empty),
    .wdata (KB_W'(shreg)),
    .rdata (kb_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign kb_ready = (fifo_count != '0);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, FIFO order, overflow, parity, timeout, reset.
module tb_ps2_kbd_rx;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 300;
  localparam int          H       = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       sig_rd_kb;
  logic [7:0] kb_rdata;
  logic       kb_ready;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;

  ps2_kbd_rx #(.KB_W(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .sig_rd_kb (sig_rd_kb),
    .kb_rdata  (kb_rdata),
    .kb_ready  (kb_ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

  initial begin
    #3ms;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {stop, parity, data[7:0], start}, sent LSB first
  function automatic logic [10:0] mk(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // Send the first n bits; optionally raise a one-cycle pop timed to hit the push edge.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_push);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_push && i == 10) begin
        repeat (3) @(posedge clk);
        @(negedge clk) sig_rd_kb = 1'b1;
        @(negedge clk) sig_rd_kb = 1'b0;
        repeat (H - 2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(mk(d, odd_par(d)), 11, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check(tag, 32'(kb_rdata), 32'(d));
    @(negedge clk) sig_rd_kb = 1'b1;
    @(negedge clk) sig_rd_kb = 1'b0;
  endtask

  initial begin
    logic [7:0] fill [DEPTH+1];
    int e0;
    int waited;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; sig_rd_kb = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_ready", 32'(kb_ready), 0);
    check("rst_rdata", 32'(kb_rdata), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single frame 0x1C
    send_bits(mk(8'h1C, 1'b0), 10, 1'b0);
    check("t1_not_ready_before_stop", 32'(kb_ready), 0);
    send_bits(mk(8'h1C, 1'b0) >> 10, 1, 1'b0);
    check("t1_ready", 32'(kb_ready), 1);
    pop_expect("t1_rdata", 8'h1C);
    check("t1_empty_after_pop", 32'(kb_ready), 0);

    // 2: three frames back to back, then drain
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h5A);
    check("t2_ready", 32'(kb_ready), 1);
    pop_expect("t2_pop0", 8'hF0);
    pop_expect("t2_pop1", 8'h1C);
    pop_expect("t2_pop2", 8'h5A);
    check("t2_empty", 32'(kb_ready), 0);
    @(negedge clk) sig_rd_kb = 1'b1;
    @(negedge clk) sig_rd_kb = 1'b0;
    check("t2_pop_empty_ignored", 32'(kb_ready), 0);
    check("t2_no_overflow", 32'(overflow), 0);

    // 4: wrong parity on 0x1C
    e0 = ferr_cnt;
    send_bits(mk(8'h1C, 1'b1), 11, 1'b0);
`ifdef PS2_PARITY_CHK_EN
    check("t4_parity_err_pulse", 32'(ferr_cnt - e0), 1);
    check("t4_parity_dropped", 32'(kb_ready), 0);
`else
    check("t4_no_err", 32'(ferr_cnt - e0), 0);
    check("t4_ready", 32'(kb_ready), 1);
    pop_expect("t4_rdata", 8'h1C);
`endif
    // bad stop bit always rejected
    e0 = ferr_cnt;
    send_bits({1'b0, odd_par(8'h3A), 8'h3A, 1'b0}, 11, 1'b0);
    check("t4_stop_err_pulse", 32'(ferr_cnt - e0), 1);
    check("t4_stop_dropped", 32'(kb_ready), 0);

    // 5: stall after 4 data bits; abort near TIMEOUT cycles after the last fall
    e0 = ferr_cnt;
    send_bits(mk(8'h29, 1'b0), 5, 1'b0);
    waited = 0;
    while (ferr_cnt == e0 && waited < TIMEOUT + 100) begin
      @(negedge clk);
      waited++;
    end
    check("t5_timeout_err", 32'(ferr_cnt - e0), 1);
    check("t5_timeout_window", 32'((waited >= TIMEOUT - 2*H - 5) && (waited <= TIMEOUT - 2*H + 10)), 1);
    repeat (5) @(negedge clk);
    check("t5_single_pulse", 32'(ferr_cnt - e0), 1);
    check("t5_nothing_pushed", 32'(kb_ready), 0);
    send_byte(8'h29);
    check("t5_ready", 32'(kb_ready), 1);
    pop_expect("t5_rdata", 8'h29);

    // 3: DEPTH+1 frames, last one dropped
    for (int i = 0; i < DEPTH + 1; i++) begin
      fill[i] = 8'(8'h10 + 8'(i) * 8'h11);
      send_byte(fill[i]);
    end
    check("t3_overflow", 32'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("t3_pop%0d", i), fill[i]);
    check("t3_extra_absent", 32'(kb_ready), 0);
    check("t3_overflow_sticky", 32'(overflow), 1);

    // reset with data buffered and a frame in flight
    send_byte(8'h77);
    send_bits(mk(8'h45, odd_par(8'h45)), 5, 1'b0);
    ps2_data = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(kb_ready), 0);
    check("rst_mid_rdata", 32'(kb_rdata), 0);
    check("rst_mid_overflow", 32'(overflow), 0);
    check("rst_mid_frame_err", 32'(frame_err), 0);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 6: fill, then pop coinciding with push of 0x33
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 8'(8'hA0 + 8'(i));
      send_byte(fill[i]);
    end
    check("t6_no_overflow_full", 32'(overflow), 0);
    send_bits(mk(8'h33, odd_par(8'h33)), 11, 1'b1);
    check("t6_no_overflow", 32'(overflow), 0);
    for (int i = 1; i < DEPTH; i++) pop_expect($sformatf("t6_pop%0d", i), fill[i]);
    check("t6_still_ready", 32'(kb_ready), 1);
    pop_expect("t6_last", 8'h33);
    check("t6_empty", 32'(kb_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
